// File: rtl/srl2par_pkg.sv
// Shared definitions for the serial-to-parallel deserialiser: bit-order
// selectors, the output holding-buffer state encoding and the helper that
// maps an accumulator index onto a word bit position.
package srl2par_pkg;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam bit SRL_LSB_FIRST = 1'b0;
  localparam bit SRL_MSB_FIRST = 1'b1;

  // Holding buffer state: EMPTY means par_vld=0, FULL means par_vld=1.
  typedef enum logic {
    OB_EMPTY = 1'b0,
    OB_FULL  = 1'b1
  } ob_state_e;

  // Word bit position that receives the serial bit with accumulator index idx.
  function automatic int unsigned bit_pos(
    input int unsigned idx,
    input int unsigned width,
    input bit          msb_first
  );
    if (msb_first) begin
      return width - 32'd1 - idx;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/srl2par_obuf.sv
// One-word output holding register with a valid/ready handshake.
// A load request while the buffer is FULL and not being emptied in the same
// cycle is refused and reported on drop_o; the held word is never disturbed
// by a refused load.
module srl2par_obuf
  import srl2par_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] par_o,
  output logic             vld_o,
  output logic             drop_o
);

  ob_state_e        state_q;
  ob_state_e        state_d;
  logic [WIDTH-1:0] par_q;
  logic [WIDTH-1:0] par_d;
  logic             load_s;
  logic             drop_s;

  // Next state, load and drop decisions for the holding buffer.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    drop_s  = 1'b0;
    case (state_q)
      OB_EMPTY: begin
        if (load_req_i) begin
          load_s  = 1'b1;
          state_d = OB_FULL;
        end else begin
          state_d = OB_EMPTY;
        end
      end
      OB_FULL: begin
        if (load_req_i) begin
          // Consumer taking the old word frees the slot for the new one.
          if (rdy_i) begin
            load_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
          state_d = OB_FULL;
        end else if (rdy_i) begin
          state_d = OB_EMPTY;
        end else begin
          state_d = OB_FULL;
        end
      end
      default: begin
        state_d = OB_EMPTY;
      end
    endcase
  end

  // Held word only changes when a new word is actually loaded.
  always_comb begin
    par_d = par_q;
    if (load_s) begin
      par_d = word_i;
    end else begin
      par_d = par_q;
    end
  end

  // Holding buffer state and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OB_EMPTY;
      par_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
    end
  end

  assign par_o  = par_q;
  assign vld_o  = (state_q == OB_FULL);
  assign drop_o = drop_s;

endmodule

// File: rtl/srl2par_nbit.sv
// Serial-to-parallel deserialiser. Gathers WIDTH qualified serial bits into a
// word (LSB-first or MSB-first), realigns on sync, and hands completed words
// to a one-word holding buffer. A completed word that finds the buffer full
// and not draining is dropped and latches the sticky ovf flag.
module srl2par_nbit
  import srl2par_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = SRL_LSB_FIRST,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srl,
  input  logic             srl_vld,
  input  logic             sync,
  output logic [WIDTH-1:0] par,
  output logic             par_vld,
  input  logic             par_rdy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] idx_s;
  int unsigned      pos_s;
  logic             complete_s;
  logic             drop_s;
  logic             ovf_q;
  logic             ovf_d;

  // Effective index of this cycle's bit: sync restarts the word at index 0.
  always_comb begin
    idx_s = cnt_q;
    if (sync) begin
      idx_s = {CNT_W{1'b0}};
    end else begin
      idx_s = cnt_q;
    end
    pos_s      = bit_pos(32'(idx_s), 32'(WIDTH), MSB_FIRST);
    complete_s = srl_vld && (idx_s == LAST_IDX);
  end

  // Write the accepted bit into its word position; other bits keep old values.
  always_comb begin
    sreg_d = sreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (srl_vld && (32'(i) == pos_s)) begin
        sreg_d[i] = srl;
      end else begin
        sreg_d[i] = sreg_q[i];
      end
    end
  end

  // Bit counter: advance on accepted bits, wrap at completion, clear on a bare sync.
  always_comb begin
    cnt_d = cnt_q;
    if (srl_vld) begin
      if (complete_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = idx_s + CNT_W'(1);
      end
    end else if (sync) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sticky overflow: a drop in the same cycle wins over a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= {WIDTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      ovf_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // The completed word includes the bit accepted on the completing edge,
  // so the buffer is fed from the accumulator's next-state value.
  srl2par_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst        (rst),
    .load_req_i (complete_s),
    .word_i     (sreg_d),
    .rdy_i      (par_rdy),
    .par_o      (par),
    .vld_o      (par_vld),
    .drop_o     (drop_s)
  );

  assign bit_cnt = cnt_q;
  assign ovf     = ovf_q;

endmodule
